// File: rtl/icache_refill_controller_if.sv
// icache_refill_controller_if: miss, flush, memory and cache-fill signals
// of the instruction cache refill controller.
interface icache_refill_controller_if #(
  parameter int NFU = 2,
  parameter int NCACHE_ENTRIES = 256,
  parameter int PHYSICAL_ADDRESS_LENGTH = 56
);
  localparam int PA    = PHYSICAL_ADDRESS_LENGTH;
  localparam int CI    = $clog2(NCACHE_ENTRIES);
  localparam int CLI   = $clog2(NFU * 4);
  localparam int TAG   = PA - CI - CLI;
  localparam int LINEW = NFU * 32 + 1 + TAG;

  logic             miss_req;
  logic [PA-1:0]    miss_addr;
  logic             miss_done;
  logic             flush_req;
  logic             flush_done;
  logic             busy;
  logic             mem_req_valid;
  logic             mem_req_ready;
  logic [PA-1:0]    mem_req_addr;
  logic             mem_resp_valid;
  logic [31:0]      mem_resp_data;
  logic             fill_we;
  logic [CI-1:0]    fill_index;
  logic [LINEW-1:0] fill_line;

  modport master (
    input  miss_req, miss_addr, flush_req,
    input  mem_req_ready, mem_resp_valid,
    input  mem_resp_data,
    output miss_done, flush_done, busy,
    output mem_req_valid, mem_req_addr,
    output fill_we, fill_index, fill_line
  );

  modport slave (
    output miss_req, miss_addr, flush_req,
    output mem_req_ready, mem_resp_valid,
    output mem_resp_data,
    input  miss_done, flush_done, busy,
    input  mem_req_valid, mem_req_addr,
    input  fill_we, fill_index, fill_line
  );
endinterface

// File: rtl/icache_refill_controller.sv
// icache_refill_controller: serial line refill plus flush sweep.
// Define ICACHE_REFILL_PERF_EN to add the performance counters.
module icache_refill_controller #(
  parameter int NFU = 2,
  parameter int NCACHE_ENTRIES = 256,
  parameter int PHYSICAL_ADDRESS_LENGTH = 56
) (
  input  logic clk,
  input  logic rst,
  icache_refill_controller_if.master bus
`ifdef ICACHE_REFILL_PERF_EN
  ,
  output logic [31:0] perf_miss_count,
  output logic [31:0] perf_refill_cycles,
  output logic [15:0] perf_flush_count
`endif
);
  localparam int PA  = PHYSICAL_ADDRESS_LENGTH;
  localparam int CI  = $clog2(NCACHE_ENTRIES);
  localparam int CLI = $clog2(NFU * 4);
  localparam int TAG = PA - CI - CLI;
  localparam int DW  = NFU * 32;
  localparam int KW  = $clog2(NFU + 1);
  localparam logic [PA-1:0] LMASK =
    ~PA'((64'd1 << CLI) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_REQ,
    S_RESP,
    S_WRITE
  } state_e;

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [CI-1:0]  cnt_q, cnt_d;
  logic [CI-1:0]  idx_q, idx_d;
  logic [TAG-1:0] tag_q, tag_d;
  logic [PA-1:0]  base_q, base_d;
  logic [DW-1:0]  data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
      base_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
      base_q  <= base_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tag_d   = tag_q;
    base_d  = base_q;
    data_d  = data_q;

    bus.busy          = (state_q != S_IDLE);
    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr  = '0;
    bus.fill_we       = 1'b0;
    bus.fill_index    = '0;
    bus.fill_line     = '0;
    bus.miss_done     = 1'b0;
    bus.flush_done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.flush_req) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else if (bus.miss_req) begin
          state_d = S_REQ;
          k_d     = '0;
          idx_d   = bus.miss_addr[CLI+CI-1:CLI];
          tag_d   = bus.miss_addr[PA-1:CI+CLI];
          base_d  = bus.miss_addr & LMASK;
          data_d  = '0;
        end
      end
      S_FLUSH: begin
        bus.fill_we    = 1'b1;
        bus.fill_index = cnt_q;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == CI'(NCACHE_ENTRIES - 1)) begin
          bus.flush_done = 1'b1;
          cnt_d          = '0;
          state_d        = S_IDLE;
        end
      end
      S_REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = base_q | PA'({k_q, 2'b00});
        if (bus.mem_req_ready) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.mem_resp_valid) begin
          data_d[32*k_q +: 32] = bus.mem_resp_data;
          k_d = k_q + 1'b1;
          // k reaches NFU here, so the line is complete
          if (k_q == KW'(NFU - 1)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_WRITE: begin
        bus.fill_we    = 1'b1;
        bus.fill_index = idx_q;
        bus.fill_line  = {1'b1, tag_q, data_q};
        bus.miss_done  = 1'b1;
        k_d            = '0;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ICACHE_REFILL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_miss_count    <= '0;
      perf_refill_cycles <= '0;
      perf_flush_count   <= '0;
    end else begin
      if (bus.miss_done) begin
        perf_miss_count <= perf_miss_count + 1'b1;
      end
      if (state_q == S_REQ || state_q == S_RESP) begin
        perf_refill_cycles <= perf_refill_cycles + 1'b1;
      end
      if (bus.flush_done) begin
        perf_flush_count <= perf_flush_count + 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_icache_refill_controller.sv
// tb_icache_refill_controller: directed refill/flush scenarios checked
// against a transaction-level model of requests and cache fills.
module tb_icache_refill_controller;
  localparam int NFU = 2;
  localparam int NC  = 256;
  localparam int PA  = 56;
  localparam int CI  = 8;
  localparam int TAG = 45;
  localparam int LW  = NFU * 32 + 1 + TAG;
  localparam int LB  = NFU * 4;

  logic clk = 1'b0;
  logic rst;

  icache_refill_controller_if #(
    .NFU(NFU), .NCACHE_ENTRIES(NC),
    .PHYSICAL_ADDRESS_LENGTH(PA)
  ) bus ();

`ifdef ICACHE_REFILL_PERF_EN
  logic [31:0] pm, pr;
  logic [15:0] pf;
`endif

  icache_refill_controller #(
    .NFU(NFU), .NCACHE_ENTRIES(NC),
    .PHYSICAL_ADDRESS_LENGTH(PA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ICACHE_REFILL_PERF_EN
    ,
    .perf_miss_count(pm),
    .perf_refill_cycles(pr),
    .perf_flush_count(pf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CI-1:0] idx;
    logic [LW-1:0] line;
    bit            mdone;
    bit            fdone;
  } fill_t;

  fill_t         exp_fill[$];
  logic [PA-1:0] exp_req[$];
  logic [PA-1:0] seen_req[$];
  logic [31:0]   mem_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0, t_idle = 0, t_miss = 0, t_flush = 0;
  int lat_miss = 0, hs_cnt = 0, fill_cnt = 0;
  logic [CI-1:0] last_idx;
  logic [LW-1:0] last_line;
  logic [PA-1:0] last_addr;
  bit pv = 0, pfd = 0;

  int rdy_wait = 0, resp_wait = 0;
  int wcnt = 0, dcnt = 0;
  bit pend = 0;
  logic [31:0] pdata;
  int stray_req = 0, stray_ack = 0;

  task automatic chk(input string nm,
                     input logic [127:0] a,
                     input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic model_miss(input logic [PA-1:0] a,
                            input logic [NFU*32-1:0] d);
    fill_t f;
    logic [PA-1:0] base;
    base = a - (a % LB);
    for (int k = 0; k < NFU; k++) begin
      exp_req.push_back(base + PA'(4 * k));
      mem_q.push_back(d[32*k +: 32]);
    end
    f.idx   = CI'((a / LB) % NC);
    f.line  = {1'b1, TAG'(a / (LB * NC)), d};
    f.mdone = 1;
    f.fdone = 0;
    exp_fill.push_back(f);
  endtask

  task automatic model_flush();
    fill_t f;
    for (int i = 0; i < NC; i++) begin
      f.idx   = CI'(i);
      f.line  = '0;
      f.mdone = 0;
      f.fdone = (i == NC - 1);
      exp_fill.push_back(f);
    end
  endtask

  // memory: optional ready stall and response delay per request
  initial begin
    bus.mem_req_ready  = 0;
    bus.mem_resp_valid = 0;
    bus.mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      bus.mem_req_ready  = 0;
      bus.mem_resp_valid = 0;
      if (rst) begin
        pend = 0;
        wcnt = 0;
        mem_q.delete();
      end else if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        bus.mem_resp_valid = 1;
        bus.mem_resp_data  = 32'hDEAD_BEEF;
      end else if (pend) begin
        if (dcnt == 0) begin
          bus.mem_resp_valid = 1;
          bus.mem_resp_data  = pdata;
          pend = 0;
        end else dcnt--;
      end else if (bus.mem_req_valid) begin
        if (wcnt < rdy_wait) wcnt++;
        else begin
          bus.mem_req_ready = 1;
          wcnt  = 0;
          pend  = 1;
          dcnt  = resp_wait;
          pdata = (mem_q.size() > 0) ?
                  mem_q.pop_front() : 32'h0;
        end
      end
    end
  end

  // compare process
  initial begin
    fill_t f;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_fill.delete();
        exp_req.delete();
        pv  = 0;
        pfd = 0;
      end else begin
        if (!bus.busy) t_idle = cyc;
        if (pfd) chk("busy_after_flush", bus.busy, 0);
        if (pv && !bus.mem_req_valid) begin
          if (exp_req.size() > 0) void'(exp_req.pop_front());
          seen_req.push_back(last_addr);
          hs_cnt++;
        end
        if (bus.mem_req_valid) begin
          if (exp_req.size() == 0)
            chk("unexpected_req", bus.mem_req_valid, 0);
          else
            chk("req_addr", bus.mem_req_addr, exp_req[0]);
          last_addr = bus.mem_req_addr;
        end
        if (bus.fill_we) begin
          fill_cnt++;
          if (exp_fill.size() == 0) begin
            chk("unexpected_fill", bus.fill_we, 0);
          end else begin
            f = exp_fill.pop_front();
            chk("fill_idx", bus.fill_index, f.idx);
            chk("fill_line", bus.fill_line, f.line);
            chk("miss_done", bus.miss_done, f.mdone);
            chk("flush_done", bus.flush_done, f.fdone);
          end
        end else if (bus.miss_done || bus.flush_done) begin
          chk("done_without_fill", bus.fill_we, 1);
        end
        if (bus.miss_done) begin
          t_miss    = cyc;
          lat_miss  = cyc - t_idle;
          last_idx  = bus.fill_index;
          last_line = bus.fill_line;
        end
        if (bus.flush_done) t_flush = cyc;
        pv  = bus.mem_req_valid;
        pfd = bus.flush_done;
      end
    end
  end

  task automatic wait_done(input bit fl, input int budget,
                           input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (((fl ? bus.flush_done : bus.miss_done) == 1'b0)
               && n < budget);
    chk(nm, fl ? bus.flush_done : bus.miss_done, 1);
  endtask

  task automatic run_miss(input logic [PA-1:0] a,
                          input logic [NFU*32-1:0] d,
                          input string nm);
    model_miss(a, d);
    bus.miss_addr = a;
    bus.miss_req  = 1;
    wait_done(0, 200, nm);
    bus.miss_req  = 0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_valid"}, bus.mem_req_valid, 0);
    chk({nm, "_addr"}, bus.mem_req_addr, 0);
    chk({nm, "_we"}, bus.fill_we, 0);
    chk({nm, "_line"}, bus.fill_line, 0);
    chk({nm, "_index"}, bus.fill_index, 0);
    chk({nm, "_dones"},
        {bus.miss_done, bus.flush_done}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int h0, f0;
    logic [LW-1:0] ref_line;
    rst = 1;
    bus.miss_req  = 0;
    bus.miss_addr = '0;
    bus.flush_req = 0;
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
`ifdef ICACHE_REFILL_PERF_EN
    chk("perf_reset", {pm, pr, pf}, 0);
`endif
    rst = 0;
    @(negedge clk);
    #1;

    seen_req.delete();
    run_miss(56'h1238, 64'hBBBB0002_AAAA0001, "basic_done");
    chk("basic_idx", last_idx, 8'h47);
    ref_line = {1'b1, 45'h2, 64'hBBBB0002_AAAA0001};
    chk("basic_line", last_line, ref_line);
    chk("basic_lat", lat_miss, 5);
    chk("basic_nreq", seen_req.size(), 2);
    if (seen_req.size() == 2) begin
      chk("basic_req0", seen_req[0], 56'h1238);
      chk("basic_req1", seen_req[1], 56'h123C);
    end
    @(negedge clk);
    #1;
    chk("basic_idle", bus.busy, 0);

    model_miss(56'h7777_1234_5670, 64'h1);
    bus.miss_addr = 56'h7777_1234_5670;
    bus.miss_req  = 1;
    wait_done(0, 200, "b2b_first");
    run_miss(56'hFF_FFFF_FFFF_FFFF, 64'hCAFE_F00D_1234_5678,
             "b2b_second");
    chk("b2b_lat", lat_miss, 5);
    chk("max_idx", last_idx, 8'hFF);

    rdy_wait  = 3;
    resp_wait = 4;
    h0 = hs_cnt;
    f0 = fill_cnt;
    run_miss(56'hABCDE0, 64'h22222222_11111111, "bp_done");
    repeat (4) @(negedge clk);
    #1;
    chk("bp_handshakes", hs_cnt - h0, NFU);
    chk("bp_fills", fill_cnt - f0, 1);
    rdy_wait  = 0;
    resp_wait = 0;

    f0 = fill_cnt;
    model_flush();
    bus.flush_req = 1;
    wait_done(1, 400, "flush_done_seen");
    bus.flush_req = 0;
    chk("flush_last_idx", bus.fill_index, 8'hFF);
    @(negedge clk);
    #1;
    chk("flush_fills", fill_cnt - f0, NC);

    model_flush();
    model_miss(56'h40, 64'h0000_0044_0000_0033);
    bus.miss_addr = 56'h40;
    bus.flush_req = 1;
    bus.miss_req  = 1;
    wait_done(1, 400, "simul_flush");
    bus.flush_req = 0;
    wait_done(0, 200, "simul_miss");
    bus.miss_req  = 0;
    chk("simul_gap", t_miss - t_flush, 6);

    h0 = hs_cnt;
    f0 = fill_cnt;
    model_miss(56'h2000, 64'h5555_5555_4444_4444);
    bus.miss_addr = 56'h2000;
    bus.miss_req  = 1;
    for (int n = 0; n < 50 && hs_cnt < h0 + 2; n++) begin
      @(negedge clk);
      #1;
    end
    chk("rst_reach_resp", hs_cnt - h0, 2);
    rst = 1;
    bus.miss_req = 0;
    repeat (2) @(negedge clk);
    #1;
    rst = 0;
    chk_zero("midrst");
    stray_req++;
    repeat (4) @(negedge clk);
    #1;
    chk("stray_no_fill", fill_cnt - f0, 0);
    chk("stray_idle", bus.busy, 0);
    run_miss(56'h2000, 64'h0000_0002_0000_0001, "clean_done");
    ref_line = {1'b1, 45'h4, 64'h0000_0002_0000_0001};
    chk("clean_line", last_line, ref_line);
    chk("clean_idx", last_idx, 8'h00);

`ifdef ICACHE_REFILL_PERF_EN
    @(negedge clk);
    #1;
    chk("perf_base_miss", pm, 1);
    chk("perf_base_flush", pf, 0);
    begin
      logic [31:0] m0, r0;
      logic [15:0] p0;
      m0 = pm;
      r0 = pr;
      p0 = pf;
      run_miss(56'h100, 64'h1, "perf_m1");
      run_miss(56'h200, 64'h2, "perf_m2");
      run_miss(56'h300, 64'h3, "perf_m3");
      model_flush();
      bus.flush_req = 1;
      wait_done(1, 400, "perf_flush");
      bus.flush_req = 0;
      @(negedge clk);
      #1;
      chk("perf_miss", pm - m0, 3);
      chk("perf_refill", pr - r0, 12);
      chk("perf_flushes", pf - p0, 1);
    end
`endif

    repeat (3) @(negedge clk);
    #1;
    chk("model_fill_drained", exp_fill.size(), 0);
    chk("model_req_drained", exp_req.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
